seq_prime_check: RTL and testbench

Parametrised sequential prime tester. It generalises the 3-bit combinational prime detector to an arbitrary WIDTH-bit unsigned operand. It uses trial division by odd divisors with a start/done handshake. Sits in the lab datapath as a multi-cycle function unit, with one operation in flight at a time.

---
 rtl/seq_prime_pkg.sv | 16 +
 rtl/seq_prime_check_mod_unit.sv | 77 +++++++
 rtl/seq_prime_check.sv | 153 +++++++++++++++
 tb/tb_seq_prime_check.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_prime_pkg.sv
// Shared definitions for the sequential prime tester: FSM encoding and width limits.
package seq_prime_pkg;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EVAL = 3'd1,
        DIV  = 3'd2,
        WAIT = 3'd3,
        NEXT = 3'd4,
        DONE = 3'd5
    } state_t;

endpackage

// File: rtl/seq_prime_check_mod_unit.sv
// Restoring shift-subtract remainder unit; one quotient bit per cycle, WIDTH cycles per operation.
module mod_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mod_start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             mod_done,
    output logic [WIDTH-1:0] rem
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             act_q, act_d;

    // Partial remainder stays below the divisor, so WIDTH+1 bits cover the shifted value.
    function automatic logic [WIDTH-1:0] rem_step(input logic [WIDTH-1:0] r,
                                                  input logic             b,
                                                  input logic [WIDTH-1:0] dv);
        logic [WIDTH:0] t;
        t = {r, b};
        if (t >= {1'b0, dv}) begin
            t = t - {1'b0, dv};
        end
        return t[WIDTH-1:0];
    endfunction

    always_comb begin
        rem_d = rem_q;
        sh_d  = sh_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        act_d = act_q;
        if (mod_start) begin
            // The first bit is consumed on the load edge so the result lands on the WIDTH-th cycle.
            rem_d = rem_step('0, dividend[WIDTH-1], divisor);
            sh_d  = {dividend[WIDTH-2:0], 1'b0};
            dvs_d = divisor;
            cnt_d = CW'(1);
            act_d = 1'b1;
        end else if (act_q) begin
            if (cnt_q == CW'(WIDTH)) begin
                act_d = 1'b0;
            end else begin
                rem_d = rem_step(rem_q, sh_q[WIDTH-1], dvs_q);
                sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q <= '0;
            sh_q  <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            act_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            sh_q  <= sh_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
            act_q <= act_d;
        end
    end

    assign mod_done = act_q && (cnt_q == CW'(WIDTH));
    assign rem      = rem_q;

endmodule

// File: rtl/seq_prime_check.sv
// Multi-cycle prime tester: trivial cases resolved up front, then trial division by odd d
// until a divisor is found or (d+2)^2 exceeds N.
module seq_prime_check
    import seq_prime_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    output logic             busy,
    output logic             done,
    output logic             is_prime
);

    localparam int             SQW = 2 * WIDTH + 2;
    localparam logic [WIDTH:0] TWO = 2;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             prime_q, prime_d;

    logic             mod_start;
    logic             mod_done;
    logic [WIDTH-1:0] mod_rem;

    logic [31:0]      n_ext;
    logic [WIDTH:0]   d_plus2;
    logic [SQW-1:0]   d_sq;
    logic [SQW-1:0]   n_wide;

    // Small-constant compares are done at 32 bits so literals such as 8 never truncate at WIDTH=2..3.
    assign n_ext   = 32'(n_q);
    assign d_plus2 = {1'b0, d_q} + TWO;
    assign d_sq    = SQW'(d_plus2) * SQW'(d_plus2);
    assign n_wide  = SQW'(n_q);

    assign mod_start = (state_q == DIV);

    mod_unit #(
        .WIDTH(WIDTH)
    ) u_mod (
        .clk      (clk),
        .rst_n    (rst_n),
        .mod_start(mod_start),
        .dividend (n_q),
        .divisor  (d_q),
        .mod_done (mod_done),
        .rem      (mod_rem)
    );

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        d_d     = d_q;
        rem_d   = rem_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        prime_d = prime_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    n_d     = A;
                    busy_d  = 1'b1;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (n_ext < 32'd2) begin
                    prime_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (n_ext == 32'd2 || n_ext == 32'd3) begin
                    prime_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (!n_q[0]) begin
                    prime_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (n_ext <= 32'd8) begin
                    prime_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    d_d     = WIDTH'(3);
                    state_d = DIV;
                end
            end
            DIV: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (mod_done) begin
                    rem_d   = mod_rem;
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (rem_q == '0) begin
                    prime_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (d_sq > n_wide) begin
                    prime_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    d_d     = d_plus2[WIDTH-1:0];
                    state_d = DIV;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            n_q     <= '0;
            d_q     <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            prime_q <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            d_q     <= d_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            prime_q <= prime_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign is_prime = prime_q;

endmodule

// File: tb/tb_seq_prime_check.sv
// Bench for seq_prime_check: arithmetic reference model with a per-cycle compare process,
// plus directed literal expectations at WIDTH=8 and a WIDTH=3 sweep.
module tb_seq_prime_check;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, start3;
    logic [W-1:0] A;
    logic [2:0]   A3;
    logic         busy, done, is_prime;
    logic         busy3, done3, is_prime3;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    // Reference model state for the operation in flight on the WIDTH=8 instance.
    logic chk_en = 1'b0;
    logic m_active = 1'b0;
    logic m_res = 1'b0;
    logic m_prev = 1'b0;
    int   m_t0 = 0;
    int   m_lat = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_prime_check #(.WIDTH(W)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .A(A),
        .busy(busy), .done(done), .is_prime(is_prime)
    );

    seq_prime_check #(.WIDTH(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .A(A3),
        .busy(busy3), .done(done3), .is_prime(is_prime3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic ref_prime(input int n);
        if (n < 2) return 1'b0;
        for (int i = 2; i * i <= n; i++) begin
            if (n % i == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Cycle in which done rises: trivial cases take 2, each odd divisor tried costs W+2 more.
    function automatic int ref_lat(input int n);
        int k;
        int d;
        if (n < 9 || n % 2 == 0) return 2;
        k = 0;
        d = 3;
        forever begin
            k++;
            if (n % d == 0 || (d + 2) * (d + 2) > n) break;
            d += 2;
        end
        return 2 + k * (W + 2);
    endfunction

    always @(negedge clk) begin
        int   j;
        logic eb, ed, ep;
        if (chk_en) begin
            j  = cyc - m_t0 + 1;
            eb = m_active && j >= 1 && j <= m_lat;
            ed = m_active && j == m_lat;
            ep = (m_active && j >= m_lat) ? m_res : m_prev;
            check("mon_busy", busy, eb);
            check("mon_done", done, ed);
            check("mon_is_prime", is_prime, ep);
        end
    end

    task automatic start_op(input logic [W-1:0] a);
        @(negedge clk);
        if (m_active) m_prev = m_res;
        m_t0     = cyc + 1;
        m_lat    = ref_lat(int'(a));
        m_res    = ref_prime(int'(a));
        m_active = 1'b1;
        start    = 1'b1;
        A        = a;
    endtask

    task automatic run_op(input logic [W-1:0] a, input int poke1, input int poke2,
                          output int lat, output logic pr);
        int j;
        start_op(a);
        lat = -1;
        pr  = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            start = 1'b0;
            A     = W'($urandom);
            j     = cyc - m_t0 + 1;
            if (j == poke1 || j == poke2) begin
                start = 1'b1;
                A     = W'(4);
            end
            if (done === 1'b1) begin
                lat = j;
                pr  = is_prime;
                break;
            end
        end
        @(negedge clk);
        start = 1'b0;
        if (lat < 0) check("done_timeout", 0, 1);
    endtask

    task automatic run_reset_mid(input logic [W-1:0] a, input int rst_at);
        logic saw_done;
        start_op(a);
        for (int i = 0; i < rst_at; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        m_active = 1'b0;
        m_prev   = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_is_prime", is_prime, 0);
        rst_n    = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("rst_mid_no_done", saw_done, 0);
    endtask

    task automatic run3(input logic [2:0] a, output int lat, output logic pr);
        int t0;
        @(negedge clk);
        start3 = 1'b1;
        A3     = a;
        t0     = cyc + 1;
        lat    = -1;
        pr     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start3 = 1'b0;
            if (done3 === 1'b1) begin
                lat = cyc - t0 + 1;
                pr  = is_prime3;
                break;
            end
        end
        @(negedge clk);
        check("w3_busy_after", busy3, 0);
    endtask

    int          dv_a   [9] = '{2, 0, 1, 4, 9, 7, 25, 251, 255};
    int          dv_lat [9] = '{2, 2, 2, 2, 12, 2, 22, 72, 12};
    logic        dv_pr  [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0]  w3_mask;
    int          lat;
    logic        pr;

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        start3 = 1'b0;
        A      = '0;
        A3     = '0;
        w3_mask = 8'b1010_1100;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_is_prime", is_prime, 0);
        chk_en = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_op(W'(dv_a[i]), -1, -1, lat, pr);
            check($sformatf("dir_lat_A%0d", dv_a[i]), lat, dv_lat[i]);
            check($sformatf("dir_prime_A%0d", dv_a[i]), pr, dv_pr[i]);
        end

        for (int a = 0; a < 256; a++) begin
            run_op(W'(a), -1, -1, lat, pr);
            check($sformatf("sweep_lat_A%0d", a), lat, ref_lat(a));
            check($sformatf("sweep_prime_A%0d", a), pr, ref_prime(a));
        end

        run_op(W'(251), 5, 40, lat, pr);
        check("repulse_lat", lat, 72);
        check("repulse_prime", pr, 1);
        run_op(W'(9), 12, -1, lat, pr);
        check("done_cycle_start_lat", lat, 12);
        check("done_cycle_start_prime", pr, 0);

        run_reset_mid(W'(251), 30);
        run_op(W'(13), -1, -1, lat, pr);
        check("post_reset_lat", lat, 12);
        check("post_reset_prime", pr, 1);

        for (int a = 0; a < 8; a++) begin
            run3(3'(a), lat, pr);
            check($sformatf("w3_lat_A%0d", a), lat, 2);
            check($sformatf("w3_prime_A%0d", a), pr, w3_mask[a]);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
